// File: rtl/dmem_bank.sv
// dmem_bank - byte-enabled data memory for the MIPS core data port.
//
// The storage array has no reset. After every reset a clear sequencer writes
// zero to one word per cycle, and requests are held off until the whole array
// is clear. Accepted requests are range-checked against a base/size window.
// Their responses come back in order through a fixed-latency pipeline.
//
// Optional feature: define DMEM_TRACE_EN to build a write-trace FIFO that
// exports {pc, word address, merged word} for every in-range write. Without
// the macro, the trace outputs are tied to 0 and trc_ready is ignored.
//
// Parameters:
//   DEPTH_WORDS - number of 32-bit words (power of 2, >= 16)
//   BASE_ADDR   - byte address of word 0 (aligned to DEPTH_WORDS*4)
//   RD_LAT      - cycles from acceptance to response (1..4)
//   TRC_DEPTH   - trace FIFO entries (power of 2, trace build only)
//
// Ports:
//   clk, reset           - rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready  - request handshake (ready is low while clearing)
//   addr, wdata, byteen  - byte address, lane-aligned data, lane enables
//                          (byteen == 0 means read)
//   inst_addr            - PC of the issuing instruction (trace only)
//   rdata, rvalid, err   - response word, read strobe, out-of-range strobe
//   busy                 - clear sequence in progress
//   trc_valid/trc_ready  - trace record handshake
//   trc_pc/addr/data     - trace record fields
//   trc_ovf              - sticky flag: a trace record was dropped

module dmem_bank #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned TRC_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  input  logic [31:0] inst_addr,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        err,
  output logic        busy,
  output logic        trc_valid,
  input  logic        trc_ready,
  output logic [31:0] trc_pc,
  output logic [31:0] trc_addr,
  output logic [31:0] trc_data,
  output logic        trc_ovf
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // Replace the enabled lanes of old_word with the same lanes of new_word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] m;
    m = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        m[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        m[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return m;
  endfunction

  // --------------------------------------------------------------------------
  // Clear sequencer FSM
  // --------------------------------------------------------------------------
  state_t        state_r, state_nxt_s;
  logic [AW-1:0] clr_idx_r, clr_idx_nxt_s;
  logic          busy_r, busy_nxt_s;
  logic          ready_r, ready_nxt_s;

  // Next-state logic: walk the clear index once, then stay idle until reset.
  always_comb begin
    state_nxt_s   = state_r;
    clr_idx_nxt_s = clr_idx_r;
    busy_nxt_s    = busy_r;
    ready_nxt_s   = ready_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_idx_r == AW'(DEPTH_WORDS - 1)) begin
          state_nxt_s   = ST_IDLE;
          clr_idx_nxt_s = '0;
          busy_nxt_s    = 1'b0;
          ready_nxt_s   = 1'b1;
        end else begin
          clr_idx_nxt_s = clr_idx_r + AW'(1);
          busy_nxt_s    = 1'b1;
          ready_nxt_s   = 1'b0;
        end
      end
      ST_IDLE: begin
        busy_nxt_s  = 1'b0;
        ready_nxt_s = 1'b1;
      end
      default: begin
        state_nxt_s   = ST_CLEAR;
        clr_idx_nxt_s = '0;
        busy_nxt_s    = 1'b1;
        ready_nxt_s   = 1'b0;
      end
    endcase
  end

  // State register; busy/ready are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_CLEAR;
      clr_idx_r <= '0;
      busy_r    <= 1'b1;
      ready_r   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      clr_idx_r <= clr_idx_nxt_s;
      busy_r    <= busy_nxt_s;
      ready_r   <= ready_nxt_s;
    end
  end

  assign busy      = busy_r;
  assign req_ready = ready_r;

  // --------------------------------------------------------------------------
  // Request decode and storage
  // --------------------------------------------------------------------------
  logic [31:0]   mem_r [DEPTH_WORDS];
  logic [31:0]   off_s;
  logic          in_range_s;
  logic [AW-1:0] widx_s;
  logic          accept_s;
  logic          is_wr_s;
  logic          wr_en_s;
  logic [31:0]   old_word_s;
  logic [31:0]   merged_s;

  // Range check and word select. The subtraction wraps, so addresses below
  // the base land far above the window and fail the check.
  always_comb begin
    off_s      = addr - BASE_ADDR;
    in_range_s = ((off_s >> 2) < 32'(DEPTH_WORDS));
    widx_s     = off_s[AW+1:2];
    accept_s   = req_valid && ready_r;
    is_wr_s    = (byteen != 4'b0000);
    wr_en_s    = accept_s && is_wr_s && in_range_s;
    old_word_s = mem_r[widx_s];
    merged_s   = byte_merge(old_word_s, wdata, byteen);
  end

  // Array write port: the clear sequencer owns it while clearing.
  always_ff @(posedge clk) begin
    if (state_r == ST_CLEAR) begin
      mem_r[clr_idx_r] <= 32'h0000_0000;
    end else if (wr_en_s) begin
      mem_r[widx_s] <= merged_s;
    end
  end

  // --------------------------------------------------------------------------
  // Response pipeline: stage 0 loads at the acceptance edge, so the response
  // appears RD_LAT-1 edges later at the last stage.
  // --------------------------------------------------------------------------
  logic        pipe_rd_r   [RD_LAT];
  logic        pipe_err_r  [RD_LAT];
  logic [31:0] pipe_data_r [RD_LAT];
  logic        st_rd_s;
  logic        st_err_s;
  logic [31:0] st_data_s;

  // Build the stage-0 entry. Data is forced to 0 unless this is an in-range
  // read, so rdata is already 0 whenever rvalid is low.
  always_comb begin
    st_rd_s  = accept_s && !is_wr_s;
    st_err_s = accept_s && !in_range_s;
    if (st_rd_s && in_range_s) begin
      st_data_s = old_word_s;
    end else begin
      st_data_s = 32'h0000_0000;
    end
  end

  // Shift the response pipeline one stage per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(RD_LAT); i++) begin
        pipe_rd_r[i]   <= 1'b0;
        pipe_err_r[i]  <= 1'b0;
        pipe_data_r[i] <= 32'h0000_0000;
      end
    end else begin
      pipe_rd_r[0]   <= st_rd_s;
      pipe_err_r[0]  <= st_err_s;
      pipe_data_r[0] <= st_data_s;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        pipe_rd_r[i]   <= pipe_rd_r[i-1];
        pipe_err_r[i]  <= pipe_err_r[i-1];
        pipe_data_r[i] <= pipe_data_r[i-1];
      end
    end
  end

  assign rvalid = pipe_rd_r[RD_LAT-1];
  assign err    = pipe_err_r[RD_LAT-1];
  assign rdata  = pipe_data_r[RD_LAT-1];

  // --------------------------------------------------------------------------
  // Write-trace FIFO
  // --------------------------------------------------------------------------
`ifdef DMEM_TRACE_EN
  localparam int unsigned PW = (TRC_DEPTH > 1) ? $clog2(TRC_DEPTH) : 1;
  localparam int unsigned CW = $clog2(TRC_DEPTH + 1);

  // Advance a FIFO pointer, wrapping after the last entry.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == PW'(TRC_DEPTH - 1)) begin
      n = '0;
    end else begin
      n = p + PW'(1);
    end
    return n;
  endfunction

  logic [31:0]   fpc_r   [TRC_DEPTH];
  logic [31:0]   faddr_r [TRC_DEPTH];
  logic [31:0]   fdata_r [TRC_DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] cnt_r;
  logic          ovf_r;
  logic          full_s;
  logic          pop_s;
  logic          do_push_s;
  logic          drop_s;

  // Push/pop decisions. A pop frees a slot in the same cycle, so a push into
  // a full FIFO still succeeds when it coincides with a pop.
  always_comb begin
    full_s    = (cnt_r == CW'(TRC_DEPTH));
    pop_s     = (cnt_r != '0) && trc_ready;
    do_push_s = wr_en_s && (!full_s || pop_s);
    drop_s    = wr_en_s && full_s && !pop_s;
  end

  // FIFO storage, pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      ovf_r    <= 1'b0;
      for (int i = 0; i < int'(TRC_DEPTH); i++) begin
        fpc_r[i]   <= 32'h0000_0000;
        faddr_r[i] <= 32'h0000_0000;
        fdata_r[i] <= 32'h0000_0000;
      end
    end else begin
      if (do_push_s) begin
        fpc_r[wr_ptr_r]   <= inst_addr;
        faddr_r[wr_ptr_r] <= {addr[31:2], 2'b00};
        fdata_r[wr_ptr_r] <= merged_s;
        wr_ptr_r          <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      if (do_push_s && !pop_s) begin
        cnt_r <= cnt_r + CW'(1);
      end else if (pop_s && !do_push_s) begin
        cnt_r <= cnt_r - CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (drop_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  assign trc_valid = (cnt_r != '0);
  assign trc_pc    = trc_valid ? fpc_r[rd_ptr_r]   : 32'h0000_0000;
  assign trc_addr  = trc_valid ? faddr_r[rd_ptr_r] : 32'h0000_0000;
  assign trc_data  = trc_valid ? fdata_r[rd_ptr_r] : 32'h0000_0000;
  assign trc_ovf   = ovf_r;
`else
  // Trace inputs are intentionally ignored in this build.
  logic unused_trc_s;
  assign unused_trc_s = ^{trc_ready, inst_addr, 32'(TRC_DEPTH)};

  assign trc_valid = 1'b0;
  assign trc_pc    = 32'h0000_0000;
  assign trc_addr  = 32'h0000_0000;
  assign trc_data  = 32'h0000_0000;
  assign trc_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_bank.sv
module tb_dmem_bank;

  localparam int          DW   = 16;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          LAT  = 3;
  localparam int          TD   = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  byteen = 4'h0;
  logic [31:0] inst_addr = 32'h0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;
  logic        busy;
  logic        trc_valid;
  logic        trc_ready = 1'b0;
  logic [31:0] trc_pc, trc_addr, trc_data;
  logic        trc_ovf;

  always #5 clk = ~clk;

  dmem_bank #(
    .DEPTH_WORDS(DW),
    .BASE_ADDR  (BASE),
    .RD_LAT     (LAT),
    .TRC_DEPTH  (TD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .addr     (addr),
    .wdata    (wdata),
    .byteen   (byteen),
    .inst_addr(inst_addr),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .err      (err),
    .busy     (busy),
    .trc_valid(trc_valid),
    .trc_ready(trc_ready),
    .trc_pc   (trc_pc),
    .trc_addr (trc_addr),
    .trc_data (trc_data),
    .trc_ovf  (trc_ovf)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          due;
    logic        rd;
    logic        er;
    logic [31:0] data;
  } resp_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] d;
  } trc_t;

  logic [31:0] mdl_mem [DW];
  resp_t       rq[$];
  trc_t        tq[$];
  logic        mdl_ovf = 1'b0;
  int          clr_edges = 0;
  int          cyc = 0;
  int          rv_cnt = 0;
  int          err_cnt = 0;

  // Model update at every rising edge, from the rules of the memory.
  always @(posedge clk) begin
    logic [31:0] off, mask, merged;
    logic        inr, is_rd, pop, full_pre;
    int          idx;
    resp_t       r;
    trc_t        t;
    cyc++;
    if (reset) begin
      clr_edges = 0;
      rq.delete();
      tq.delete();
      mdl_ovf = 1'b0;
      for (int i = 0; i < DW; i++) mdl_mem[i] = 32'h0;
    end else if (clr_edges < DW) begin
      clr_edges++;
    end else begin
      pop = 1'b0;
`ifdef DMEM_TRACE_EN
      full_pre = (tq.size() == TD);
      pop = (tq.size() > 0) && trc_ready;
      if (pop) void'(tq.pop_front());
`else
      full_pre = 1'b0;
`endif
      if (req_valid) begin
        off   = addr - BASE;
        inr   = (off / 4) < DW;
        idx   = int'(off[5:2]);
        is_rd = (byteen == 4'h0);
        r.due  = cyc + LAT - 1;
        r.rd   = is_rd;
        r.er   = !inr;
        r.data = (is_rd && inr) ? mdl_mem[idx] : 32'h0;
        rq.push_back(r);
        if (!is_rd && inr) begin
          mask = {{8{byteen[3]}}, {8{byteen[2]}}, {8{byteen[1]}}, {8{byteen[0]}}};
          merged = (mdl_mem[idx] & ~mask) | (wdata & mask);
          mdl_mem[idx] = merged;
          t.pc = inst_addr;
          t.a  = addr & 32'hFFFF_FFFC;
          t.d  = merged;
`ifdef DMEM_TRACE_EN
          if (!full_pre || pop) tq.push_back(t);
          else mdl_ovf = 1'b1;
`endif
        end
      end
    end
  end

  // Compare all outputs against the model on every falling edge.
  always @(negedge clk) begin
    logic        e_rv, e_er;
    logic [31:0] e_rd;
    logic        e_tv;
    logic [31:0] e_pc, e_ta, e_td;
    logic        e_ovf;
    if (rvalid === 1'b1) rv_cnt++;
    if (err === 1'b1) err_cnt++;
    if (reset) begin
      check("rst_busy", {31'h0, busy}, 32'h1);
      check("rst_ready", {31'h0, req_ready}, 32'h0);
      check("rst_rvalid", {31'h0, rvalid}, 32'h0);
      check("rst_err", {31'h0, err}, 32'h0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_trc", {31'h0, trc_valid | trc_ovf | (|trc_pc) | (|trc_addr) | (|trc_data)}, 32'h0);
    end else begin
      e_rv = 1'b0; e_er = 1'b0; e_rd = 32'h0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        e_rv = rq[0].rd;
        e_er = rq[0].er;
        e_rd = rq[0].data;
        void'(rq.pop_front());
      end
      check("busy", {31'h0, busy}, {31'h0, clr_edges < DW});
      check("req_ready", {31'h0, req_ready}, {31'h0, clr_edges == DW});
      check("rvalid", {31'h0, rvalid}, {31'h0, e_rv});
      check("err", {31'h0, err}, {31'h0, e_er});
      check("rdata", rdata, e_rd);
      e_tv = 1'b0; e_pc = 32'h0; e_ta = 32'h0; e_td = 32'h0; e_ovf = 1'b0;
`ifdef DMEM_TRACE_EN
      e_ovf = mdl_ovf;
      if (tq.size() > 0) begin
        e_tv = 1'b1; e_pc = tq[0].pc; e_ta = tq[0].a; e_td = tq[0].d;
      end
`endif
      check("trc_valid", {31'h0, trc_valid}, {31'h0, e_tv});
      check("trc_pc", trc_pc, e_pc);
      check("trc_addr", trc_addr, e_ta);
      check("trc_data", trc_data, e_td);
      check("trc_ovf", {31'h0, trc_ovf}, {31'h0, e_ovf});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [31:0] pc);
    req_valid = 1'b1; addr = a; wdata = d; byteen = be; inst_addr = pc;
    step();
    req_valid = 1'b0; byteen = 4'h0;
  endtask

  // Sample the response of the read issued just before this call.
  task automatic expect_read(input string name, input logic [31:0] exp);
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    check({name, "_rvalid"}, {31'h0, rvalid}, 32'h1);
    check({name, "_rdata"}, rdata, exp);
  endtask

  // Release reset and count busy cycles (bounded).
  task automatic release_and_count(input string name);
    int n;
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 3 * DW; i++) begin
      @(negedge clk);
      if (busy === 1'b1) n++;
      else break;
    end
    check(name, n, DW);
  endtask

  initial begin
    int e0, r0;
    #200_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, r0;
    repeat (3) step();
    release_and_count("busy_cycles");

    // Read of a freshly cleared word.
    issue(BASE + 32'h8, 32'h0, 4'h0, 32'h100);
    expect_read("clear_read", 32'h0);

    // Lane merge.
    issue(BASE + 32'h10, 32'h1122_3344, 4'hF, 32'h104);
    issue(BASE + 32'h12, 32'h0000_AB00, 4'b0010, 32'h108);
    issue(BASE + 32'h10, 32'h0, 4'h0, 32'h10C);
    expect_read("merge", 32'h1122_AB44);

    // Four back-to-back reads after distinct writes.
    for (int i = 1; i <= 4; i++) issue(BASE + 32'(4 * i), 32'hA0 + 32'(i), 4'hF, 32'h200);
    r0 = rv_cnt;
    for (int i = 1; i <= 4; i++) issue(BASE + 32'(4 * i), 32'h0, 4'h0, 32'h204);
    repeat (LAT + 2) step();
    check("b2b_rvalid_count", rv_cnt - r0, 4);

    // Out-of-range write below the base and read just past the window.
    e0 = err_cnt; r0 = rv_cnt;
    issue(32'h0000_0FFC, 32'hDEAD_BEEF, 4'hF, 32'h300);
    issue(BASE + 32'(4 * DW), 32'h0, 4'h0, 32'h304);
    repeat (LAT + 2) step();
    check("oob_err_count", err_cnt - e0, 2);
    check("oob_rvalid_count", rv_cnt - r0, 1);
    issue(BASE, 32'h0, 4'h0, 32'h308);
    expect_read("oob_no_change", 32'h0);

    // Reset at clear index 5.
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    repeat (2) step();
    release_and_count("busy_after_midclear");
    issue(BASE + 32'h10, 32'h0, 4'h0, 32'h30C);
    expect_read("cleared_again", 32'h0);

    // Trace: five writes with the consumer stalled.
    trc_ready = 1'b0;
    issue(BASE, 32'hA1B2_C3D4, 4'b0011, 32'h0000_0400);
    for (int i = 1; i < 5; i++) issue(BASE + 32'(4 * i), 32'h5500 + 32'(i), 4'hF, 32'h400 + 32'(4 * i));
    @(negedge clk);
`ifdef DMEM_TRACE_EN
    check("trc_full_valid", {31'h0, trc_valid}, 32'h1);
    check("trc_full_ovf", {31'h0, trc_ovf}, 32'h1);
    check("trc_first_pc", trc_pc, 32'h0000_0400);
    check("trc_first_addr", trc_addr, BASE);
    check("trc_first_data", trc_data, 32'h0000_C3D4);
    trc_ready = 1'b1;
    repeat (4) step();
    trc_ready = 1'b0;
    @(negedge clk);
    check("trc_drained", {31'h0, trc_valid}, 32'h0);
    check("trc_ovf_sticky", {31'h0, trc_ovf}, 32'h1);
`else
    check("trc_off_valid", {31'h0, trc_valid}, 32'h0);
    check("trc_off_ovf", {31'h0, trc_ovf}, 32'h0);
`endif

    // Randomized traffic with one reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
      end
      trc_ready = ($urandom_range(0, 3) != 0);
      req_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       addr = $urandom();
        1:       addr = BASE - 32'(4 * $urandom_range(1, 2));
        2:       addr = BASE + 32'(4 * DW) + 32'($urandom_range(0, 7));
        default: addr = BASE + 32'(4 * $urandom_range(0, DW - 1)) + 32'($urandom_range(0, 3));
      endcase
      wdata     = $urandom();
      byteen    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      inst_addr = $urandom() & 32'hFFFF_FFFC;
      step();
    end
    req_valid = 1'b0;
    trc_ready = 1'b1;
    repeat (LAT + TD + 4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
